// File: rtl/cu_pkg.sv
// cu_pkg: opcodes, control encodings, decode kinds and FSM state type shared by cu_seq and cu_decode
package cu_pkg;

    localparam logic [3:0] OP_ADD    = 4'h0;
    localparam logic [3:0] OP_SUB    = 4'h1;
    localparam logic [3:0] OP_MUL    = 4'h2;
    localparam logic [3:0] OP_MEMW   = 4'h3;
    localparam logic [3:0] OP_MEMSEL = 4'h4;
    localparam logic [3:0] OP_SIG    = 4'h5;
    localparam logic [3:0] OP_RELU   = 4'h6;
    localparam logic [3:0] OP_DSIG   = 4'h7;
    localparam logic [3:0] OP_HALT   = 4'hE;
    localparam logic [3:0] OP_NOP    = 4'hF;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_MUL = 2'b10;

    localparam logic [1:0] DST_MEM  = 2'b00;
    localparam logic [1:0] DST_SIG  = 2'b01;
    localparam logic [1:0] DST_RELU = 2'b10;
    localparam logic [1:0] DST_DSIG = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_HALT
    } state_e;

    typedef enum logic [1:0] {
        K_EXEC,
        K_HALT,
        K_NOP,
        K_ILL
    } kind_e;

    typedef struct packed {
        logic       en_alu;
        logic [1:0] op_sel;
        logic       en_wm;
        logic       en_sm;
        logic [1:0] dest;
        logic       oprnd2;
    } ctrl_t;

    function automatic ctrl_t mk_ctrl(
        input logic       en_alu,
        input logic [1:0] op_sel,
        input logic       en_wm,
        input logic       en_sm,
        input logic [1:0] dest,
        input logic       oprnd2
    );
        return '{en_alu: en_alu, op_sel: op_sel, en_wm: en_wm, en_sm: en_sm, dest: dest, oprnd2: oprnd2};
    endfunction

endpackage

// File: rtl/cu_decode.sv
// cu_decode: combinational opcode to control-word and instruction-kind table for cu_seq
module cu_decode
    import cu_pkg::*;
#(
    parameter int OP_WIDTH = 4
) (
    input  logic [OP_WIDTH-1:0] op,
    output ctrl_t               ctrl,
    output kind_e               kind,
    output logic                is_mul
);

    logic [3:0] lo;
    logic       hi_nz;

    assign lo     = op[3:0];
    assign hi_nz  = |(op >> 4);
    assign is_mul = (kind == K_EXEC) && (lo == OP_MUL);

    // Any set bit above bit 3 makes the opcode illegal regardless of the low nibble
    always_comb begin
        ctrl = '0;
        kind = K_ILL;
        if (!hi_nz) begin
            case (lo)
                OP_ADD:    begin kind = K_EXEC; ctrl = mk_ctrl(1'b1, ALU_ADD, 1'b1, 1'b0, DST_MEM,  1'b0); end
                OP_SUB:    begin kind = K_EXEC; ctrl = mk_ctrl(1'b1, ALU_SUB, 1'b1, 1'b0, DST_MEM,  1'b0); end
                OP_MUL:    begin kind = K_EXEC; ctrl = mk_ctrl(1'b1, ALU_MUL, 1'b1, 1'b0, DST_MEM,  1'b0); end
                OP_MEMW:   begin kind = K_EXEC; ctrl = mk_ctrl(1'b0, ALU_ADD, 1'b1, 1'b0, DST_MEM,  1'b0); end
                OP_MEMSEL: begin kind = K_EXEC; ctrl = mk_ctrl(1'b0, ALU_ADD, 1'b0, 1'b1, DST_MEM,  1'b0); end
                OP_SIG:    begin kind = K_EXEC; ctrl = mk_ctrl(1'b1, ALU_ADD, 1'b1, 1'b0, DST_SIG,  1'b1); end
                OP_RELU:   begin kind = K_EXEC; ctrl = mk_ctrl(1'b1, ALU_ADD, 1'b1, 1'b0, DST_RELU, 1'b1); end
                OP_DSIG:   begin kind = K_EXEC; ctrl = mk_ctrl(1'b1, ALU_ADD, 1'b1, 1'b0, DST_DSIG, 1'b1); end
                OP_HALT:   kind = K_HALT;
                OP_NOP:    kind = K_NOP;
                default:   kind = K_ILL;
            endcase
        end
    end

endmodule

// File: rtl/cu_seq.sv
// cu_seq: sequenced control unit expanding opcode+count instructions into registered control beats.
// Optional macro CU_SEQ_ILLEGAL_TRAP_EN: illegal opcodes set a sticky illegal flag and halt instead of acting as NOP.
module cu_seq
    import cu_pkg::*;
#(
    parameter int OP_WIDTH  = 4,
    parameter int CNT_WIDTH = 8,
    parameter int MUL_LAT   = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 instr_valid,
    output logic                 instr_ready,
    input  logic [OP_WIDTH-1:0]  instr_op,
    input  logic [CNT_WIDTH-1:0] instr_cnt,
    input  logic                 stall,
    output logic                 en_writeMem,
    output logic                 en_alu,
    output logic                 en_selMem,
    output logic                 oprnd2_sel,
    output logic [1:0]           op_sel,
    output logic [1:0]           dest_control,
    output logic [CNT_WIDTH-1:0] elem_idx,
    output logic                 done,
    output logic                 halted
`ifdef CU_SEQ_ILLEGAL_TRAP_EN
    ,
    output logic                 illegal
`endif
);

    localparam int            BW        = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [BW-1:0] BEAT_LAST = BW'(MUL_LAT - 1);

    state_e               state_q, state_d;
    logic [OP_WIDTH-1:0]  op_q, op_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] elem_q, elem_d;
    logic [BW-1:0]        beat_q, beat_d;
    logic                 last_q, last_d;
    logic                 nop_q, nop_d;
    logic                 en_wm_q, en_wm_d;
    logic                 en_alu_q, en_alu_d;
    logic                 en_sm_q, en_sm_d;
    logic                 oprnd2_q, oprnd2_d;
    logic [1:0]           op_sel_q, op_sel_d;
    logic [1:0]           dest_q, dest_d;
    logic [CNT_WIDTH-1:0] elem_idx_q, elem_idx_d;
    logic                 done_q, done_d;
    logic                 halted_q, halted_d;
`ifdef CU_SEQ_ILLEGAL_TRAP_EN
    logic                 illegal_q, illegal_d;
`endif

    ctrl_t               ctrl;
    kind_e               kind;
    logic                is_mul;
    logic                beat_end;
    logic                fin;
    logic [OP_WIDTH-1:0] dec_op;

    // In IDLE the decoder classifies the offered opcode; otherwise it drives the latched one
    assign dec_op = (state_q == ST_IDLE) ? instr_op : op_q;

    cu_decode #(
        .OP_WIDTH(OP_WIDTH)
    ) u_dec (
        .op    (dec_op),
        .ctrl  (ctrl),
        .kind  (kind),
        .is_mul(is_mul)
    );

    assign instr_ready  = (state_q == ST_IDLE) && rst_n;
    assign beat_end     = !is_mul || (beat_q == BEAT_LAST);
    assign fin          = beat_end && (elem_q == cnt_q);

    assign en_writeMem  = en_wm_q;
    assign en_alu       = en_alu_q;
    assign en_selMem    = en_sm_q;
    assign oprnd2_sel   = oprnd2_q;
    assign op_sel       = op_sel_q;
    assign dest_control = dest_q;
    assign elem_idx     = elem_idx_q;
    assign done         = done_q;
    assign halted       = halted_q;
`ifdef CU_SEQ_ILLEGAL_TRAP_EN
    assign illegal      = illegal_q;
`endif

    // Next state and next registered outputs; last_q marks the turnaround cycle after the final beat
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        cnt_d      = cnt_q;
        elem_d     = elem_q;
        beat_d     = beat_q;
        last_d     = last_q;
        nop_d      = 1'b0;
        en_wm_d    = 1'b0;
        en_alu_d   = 1'b0;
        en_sm_d    = 1'b0;
        oprnd2_d   = 1'b0;
        op_sel_d   = '0;
        dest_d     = '0;
        elem_idx_d = '0;
        done_d     = 1'b0;
`ifdef CU_SEQ_ILLEGAL_TRAP_EN
        illegal_d  = illegal_q;
`endif
        case (state_q)
            ST_IDLE: begin
                done_d = nop_q;
                if (instr_valid) begin
                    op_d   = instr_op;
                    cnt_d  = instr_cnt;
                    elem_d = '0;
                    beat_d = '0;
                    last_d = 1'b0;
`ifdef CU_SEQ_ILLEGAL_TRAP_EN
                    nop_d     = (kind == K_NOP);
                    illegal_d = illegal_q || (kind == K_ILL);
                    state_d   = (kind == K_EXEC) ? ST_EXEC :
                                (kind == K_HALT || kind == K_ILL) ? ST_HALT : ST_IDLE;
`else
                    nop_d   = (kind == K_NOP) || (kind == K_ILL);
                    state_d = (kind == K_EXEC) ? ST_EXEC : (kind == K_HALT) ? ST_HALT : ST_IDLE;
`endif
                end
            end
            ST_EXEC: begin
                if (last_q) begin
                    state_d = ST_IDLE;
                end else if (stall) begin
                    op_sel_d   = op_sel_q;
                    dest_d     = dest_q;
                    elem_idx_d = elem_idx_q;
                end else begin
                    en_alu_d   = ctrl.en_alu;
                    en_wm_d    = ctrl.en_wm && beat_end;
                    en_sm_d    = ctrl.en_sm;
                    oprnd2_d   = ctrl.oprnd2;
                    op_sel_d   = ctrl.op_sel;
                    dest_d     = ctrl.dest;
                    elem_idx_d = elem_q;
                    done_d     = fin;
                    last_d     = fin;
                    beat_d     = beat_end ? '0 : beat_q + 1'b1;
                    elem_d     = (beat_end && !fin) ? elem_q + 1'b1 : elem_q;
                end
            end
            default: begin
            end
        endcase
        halted_d = (state_d == ST_HALT);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            op_q       <= '0;
            cnt_q      <= '0;
            elem_q     <= '0;
            beat_q     <= '0;
            last_q     <= 1'b0;
            nop_q      <= 1'b0;
            en_wm_q    <= 1'b0;
            en_alu_q   <= 1'b0;
            en_sm_q    <= 1'b0;
            oprnd2_q   <= 1'b0;
            op_sel_q   <= '0;
            dest_q     <= '0;
            elem_idx_q <= '0;
            done_q     <= 1'b0;
            halted_q   <= 1'b0;
`ifdef CU_SEQ_ILLEGAL_TRAP_EN
            illegal_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            cnt_q      <= cnt_d;
            elem_q     <= elem_d;
            beat_q     <= beat_d;
            last_q     <= last_d;
            nop_q      <= nop_d;
            en_wm_q    <= en_wm_d;
            en_alu_q   <= en_alu_d;
            en_sm_q    <= en_sm_d;
            oprnd2_q   <= oprnd2_d;
            op_sel_q   <= op_sel_d;
            dest_q     <= dest_d;
            elem_idx_q <= elem_idx_d;
            done_q     <= done_d;
            halted_q   <= halted_d;
`ifdef CU_SEQ_ILLEGAL_TRAP_EN
            illegal_q  <= illegal_d;
`endif
        end
    end

endmodule

// File: tb/tb_cu_seq.sv
// tb_cu_seq: table-driven directed bench for cu_seq (default parameters, optional CU_SEQ_ILLEGAL_TRAP_EN)
module tb_cu_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       instr_valid = 1'b0;
    logic       instr_ready;
    logic [3:0] instr_op = 4'h0;
    logic [7:0] instr_cnt = 8'h0;
    logic       stall = 1'b0;
    logic       en_writeMem, en_alu, en_selMem, oprnd2_sel, done, halted;
    logic [1:0] op_sel, dest_control;
    logic [7:0] elem_idx;
    logic       ill_a;
`ifdef CU_SEQ_ILLEGAL_TRAP_EN
    logic       illegal;
    assign ill_a = illegal;
`else
    assign ill_a = 1'b0;
`endif

    cu_seq #(
        .OP_WIDTH (4),
        .CNT_WIDTH(8),
        .MUL_LAT  (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_op    (instr_op),
        .instr_cnt   (instr_cnt),
        .stall       (stall),
        .en_writeMem (en_writeMem),
        .en_alu      (en_alu),
        .en_selMem   (en_selMem),
        .oprnd2_sel  (oprnd2_sel),
        .op_sel      (op_sel),
        .dest_control(dest_control),
        .elem_idx    (elem_idx),
        .done        (done),
        .halted      (halted)
`ifdef CU_SEQ_ILLEGAL_TRAP_EN
        ,
        .illegal     (illegal)
`endif
    );

    always #5 clk = ~clk;

    // Control byte {en_writeMem, en_alu, en_selMem, oprnd2_sel, op_sel, dest_control}
    localparam logic [7:0] C_ADD  = 8'b1100_0000;
    localparam logic [7:0] C_SUB  = 8'b1100_0100;
    localparam logic [7:0] C_MUL  = 8'b1100_1000;
    localparam logic [7:0] C_MULH = 8'b0100_1000;
    localparam logic [7:0] C_MSTL = 8'b0000_1000;
    localparam logic [7:0] C_MEMW = 8'b1000_0000;
    localparam logic [7:0] C_SEL  = 8'b0010_0000;
    localparam logic [7:0] C_SIG  = 8'b1101_0001;
    localparam logic [7:0] C_RELU = 8'b1101_0010;
    localparam logic [7:0] C_RSTL = 8'b0000_0010;
    localparam logic [7:0] C_DSIG = 8'b1101_0011;

    // Expected word {instr_ready, ctrl[7:0], elem_idx[7:0], done, halted, illegal}
    typedef struct {
        logic        r;
        logic        v;
        logic [3:0]  op;
        logic [7:0]  cnt;
        logic        st;
        logic [19:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic logic [19:0] z_o(input logic rdy);
        return {rdy, 8'h00, 8'h00, 3'b000};
    endfunction

    function automatic logic [19:0] b_o(input logic [7:0] c, input logic [7:0] idx, input logic d);
        return {1'b0, c, idx, d, 2'b00};
    endfunction

    function automatic logic [19:0] h_o(input logic ill);
        return {1'b0, 8'h00, 8'h00, 1'b0, 1'b1, ill};
    endfunction

    function automatic logic [19:0] d_o(input logic rdy);
        return {rdy, 8'h00, 8'h00, 3'b100};
    endfunction

    task automatic row(input logic r, input logic v, input logic [3:0] op, input logic [7:0] cnt,
                       input logic st, input logic [19:0] exp);
        vec_t t;
        t.r = r; t.v = v; t.op = op; t.cnt = cnt; t.st = st; t.exp = exp;
        tbl.push_back(t);
    endtask

    task automatic step(input vec_t t, input string nm);
        logic [19:0] got;
        rst_n       = t.r;
        instr_valid = t.v;
        instr_op    = t.op;
        instr_cnt   = t.cnt;
        stall       = t.st;
        @(posedge clk);
        #1;
        got = {instr_ready, en_writeMem, en_alu, en_selMem, oprnd2_sel, op_sel, dest_control,
               elem_idx, done, halted, ill_a};
        n_vec++;
        if (got !== t.exp) begin
            n_bad++;
            $display("FAIL %s: got %05h expected %05h", nm, got, t.exp);
        end
    endtask

    task automatic hs(input logic r, input logic v, input logic [3:0] op, input logic [7:0] cnt,
                      input logic st, input logic [19:0] exp, input string nm);
        vec_t t;
        t.r = r; t.v = v; t.op = op; t.cnt = cnt; t.st = st; t.exp = exp;
        step(t, nm);
    endtask

    initial begin
        // reset, then idle
        row(0, 0, 4'h0, 0, 0, z_o(0));
        row(1, 0, 4'h0, 0, 0, z_o(1));
        // add count 3
        row(1, 1, 4'h0, 3, 0, z_o(0));
        row(1, 0, 4'h0, 0, 0, b_o(C_ADD, 0, 0));
        row(1, 0, 4'h0, 0, 0, b_o(C_ADD, 1, 0));
        row(1, 0, 4'h0, 0, 0, b_o(C_ADD, 2, 0));
        row(1, 0, 4'h0, 0, 0, b_o(C_ADD, 3, 1));
        row(1, 0, 4'h0, 0, 0, z_o(1));
        // mul count 1, three cycles per beat
        row(1, 1, 4'h2, 1, 0, z_o(0));
        row(1, 0, 4'h0, 0, 0, b_o(C_MULH, 0, 0));
        row(1, 0, 4'h0, 0, 0, b_o(C_MULH, 0, 0));
        row(1, 0, 4'h0, 0, 0, b_o(C_MUL, 0, 0));
        row(1, 0, 4'h0, 0, 0, b_o(C_MULH, 1, 0));
        row(1, 0, 4'h0, 0, 0, b_o(C_MULH, 1, 0));
        row(1, 0, 4'h0, 0, 0, b_o(C_MUL, 1, 1));
        row(1, 0, 4'h0, 0, 0, z_o(1));
        // relu count 2 with a two-cycle stall on element 1
        row(1, 1, 4'h6, 2, 0, z_o(0));
        row(1, 0, 4'h0, 0, 0, b_o(C_RELU, 0, 0));
        row(1, 0, 4'h0, 0, 0, b_o(C_RELU, 1, 0));
        row(1, 0, 4'h0, 0, 1, b_o(C_RSTL, 1, 0));
        row(1, 0, 4'h0, 0, 1, b_o(C_RSTL, 1, 0));
        row(1, 0, 4'h0, 0, 0, b_o(C_RELU, 2, 1));
        row(1, 0, 4'h0, 0, 0, z_o(1));
        // single-element sub, memwrite, dsigmoid (stall ignored while idle)
        row(1, 1, 4'h1, 0, 0, z_o(0));
        row(1, 0, 4'h0, 0, 0, b_o(C_SUB, 0, 1));
        row(1, 0, 4'h0, 0, 0, z_o(1));
        row(1, 1, 4'h3, 0, 0, z_o(0));
        row(1, 0, 4'h0, 0, 0, b_o(C_MEMW, 0, 1));
        row(1, 0, 4'h0, 0, 0, z_o(1));
        row(1, 1, 4'h7, 0, 1, z_o(0));
        row(1, 0, 4'h0, 0, 0, b_o(C_DSIG, 0, 1));
        row(1, 0, 4'h0, 0, 0, z_o(1));
        // mul count 0 with a stall mid-beat: op_sel holds, strobes drop
        row(1, 1, 4'h2, 0, 0, z_o(0));
        row(1, 0, 4'h0, 0, 0, b_o(C_MULH, 0, 0));
        row(1, 0, 4'h0, 0, 1, b_o(C_MSTL, 0, 0));
        row(1, 0, 4'h0, 0, 0, b_o(C_MULH, 0, 0));
        row(1, 0, 4'h0, 0, 0, b_o(C_MUL, 0, 1));
        row(1, 0, 4'h0, 0, 0, z_o(1));
        // NOP ignores count, done one cycle after accept
        row(1, 1, 4'hF, 9, 0, z_o(1));
        row(1, 0, 4'h0, 0, 0, d_o(1));
        row(1, 0, 4'h0, 0, 0, z_o(1));
`ifdef CU_SEQ_ILLEGAL_TRAP_EN
        // illegal opcode traps into HALT with sticky flag
        row(1, 1, 4'hA, 5, 0, h_o(1));
        row(1, 1, 4'h0, 0, 0, h_o(1));
        row(0, 0, 4'h0, 0, 0, z_o(0));
        row(1, 0, 4'h0, 0, 0, z_o(1));
`else
        // illegal opcode behaves as NOP, next instruction accepted right away
        row(1, 1, 4'hA, 5, 0, z_o(1));
        row(1, 1, 4'h0, 0, 0, d_o(0));
        row(1, 0, 4'h0, 0, 0, b_o(C_ADD, 0, 1));
        row(1, 0, 4'h0, 0, 0, z_o(1));
`endif
        // HALT refuses further instructions until reset
        row(1, 1, 4'hE, 0, 0, h_o(0));
        row(1, 1, 4'h0, 0, 0, h_o(0));
        row(1, 1, 4'h0, 0, 0, h_o(0));
        row(1, 1, 4'h0, 0, 0, h_o(0));
        row(0, 1, 4'h0, 0, 0, z_o(0));
        row(1, 0, 4'h0, 0, 0, z_o(1));

        foreach (tbl[i]) step(tbl[i], $sformatf("tbl%0d", i));

        // reset during the second beat of sigmoid count 5 aborts without done
        hs(1, 1, 4'h5, 5, 0, z_o(0), "sig_acc");
        hs(1, 0, 4'h0, 0, 0, b_o(C_SIG, 0, 0), "sig_b0");
        hs(1, 0, 4'h0, 0, 0, b_o(C_SIG, 1, 0), "sig_b1");
        hs(0, 0, 4'h0, 0, 0, z_o(0), "sig_rst");
        hs(1, 0, 4'h0, 0, 0, z_o(1), "sig_rel");
        hs(1, 0, 4'h0, 0, 0, z_o(1), "sig_nodone");

        // full-range count: 256 memsel beats, elem_idx ends at 255 with done
        hs(1, 1, 4'h4, 8'hFF, 0, z_o(0), "wrap_acc");
        for (int i = 0; i < 256; i++)
            hs(1, 0, 4'h0, 0, 0, b_o(C_SEL, 8'(i), i == 255), $sformatf("wrap_b%0d", i));
        hs(1, 0, 4'h0, 0, 0, z_o(1), "wrap_end");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
